freecell_move_ctrl: RTL and testbench
=====================================

Name: freecell_move_ctrl

Overview:
- Sequential move controller directly upstream of the FreeCell move-legality checker.
- Accepts a move request (source, dest), fetches both piles' top card and depth from board storage, and drives the checker's inputs.
- Samples the checker's verdict; on a legal move, commits a pop/push to board storage.
- Returns a fixed-latency response and keeps move/home statistics, including a sticky game-won flag.

Parameters:
COL_DEPTH, 19, maximum cards in one tableau column; a column at this depth is full
CNT_W, 16, width of the move and reject counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  move request present
req_ready  out  1  controller idle, able to accept a request
req_source  in  4  source location: 0-7 tableau, 8-11 free cell (10xx), 12-15 home (11xx)
req_dest  in  4  destination location, same encoding
resp_valid  out  1  one-cycle response strobe
resp_ok  out  1  move committed (valid only with resp_valid)
rd_loc  out  4  board read address
rd_card  in  6  top card of rd_loc, {suit[5:4], rank[3:0]}, rank 1-13; returned the cycle after rd_loc is presented
rd_count  in  5  cards currently in rd_loc; same timing as rd_card
pop_en  out  1  remove top card of pop_loc
pop_loc  out  4  pop location
push_en  out  1  push push_card onto push_loc
push_loc  out  4  push location
push_card  out  6  card being moved
lg_source  out  4  to checker: source
lg_dest  out  4  to checker: dest
lg_src_empty  out  1  to checker
lg_dest_full  out  1  to checker
lg_dest_empty  out  1  to checker
lg_src_card  out  6  to checker
lg_dest_card  out  6  to checker
lg_valid  in  1  checker verdict (combinational from lg_* inputs)
move_count  out  CNT_W  committed moves
reject_count  out  CNT_W  rejected requests
game_won  out  1  sticky; set when all 52 cards are home

Behaviour:
- Reset values:
  - State IDLE, req_ready=1.
  - resp_valid=0, resp_ok=0, pop_en=0, push_en=0.
  - All lg_* registers 0; rd_loc=0, pop_loc=0, push_loc=0, push_card=0.
  - move_count=0, reject_count=0, game_won=0, internal home counter=0.
- All outputs are registered. lg_* outputs are held stable from CAPT through EVAL.
- FSM: IDLE -> RDSRC -> RDDST -> CAPT -> EVAL -> COMMIT -> RESP -> IDLE.
  - IDLE: req_ready=1. When req_valid&req_ready, latch source/dest, drop req_ready, go to RDSRC. req_ready is 0 in every other state; requests arriving then are ignored, not queued.
  - RDSRC: rd_loc=source.
  - RDDST: rd_loc=dest. Capture rd_card/rd_count as source data.
  - CAPT: capture dest data. Load lg_* from the captured data:
    - src_empty = (src count==0); dest_empty = (dest count==0).
    - dest_full = free cell with count>=1, or home with count>=13, or tableau with count>=COL_DEPTH.
  - EVAL: register verdict ok = lg_valid & ~game_won.
  - COMMIT: if ok, assert pop_en/push_en together for exactly one cycle, with pop_loc=source, push_loc=dest, push_card=src card. Otherwise no write.
  - RESP: resp_valid=1 for one cycle with resp_ok=ok, then return to IDLE.
- Latency: resp_valid is asserted exactly 6 cycles after the acceptance cycle, for both accept and reject. A new request can be accepted the cycle after RESP, giving 7 cycles per move.
- Counters:
  - In COMMIT, if ok: move_count += 1. If dest[3:2]==11, the home counter += 1.
  - In COMMIT, if not ok: reject_count += 1.
  - Both counters wrap modulo 2^CNT_W.
- game_won: set the cycle after the home counter reaches 52; cleared only by rst. While set, every request is rejected with the same latency and no board write.
- source==dest and source in home are rejected by the checker; the controller needs no special-casing.
- Reset mid-operation: return to IDLE next edge. Any pending commit or response is dropped; no pop/push or resp_valid is emitted.

Test Plan:
- After rst, req source=0 (count 3, card {2,5}), dest=8 (count 0), lg_valid=1 -> rd_loc sequence 0 then 8; pop_en/push_en one cycle with pop_loc=0, push_loc=8, push_card=6'b10_0101; resp_valid+resp_ok 6 cycles after acceptance; move_count=1.
- Source=9 free cell with count 0 -> lg_src_empty=1; checker returns 0 -> no write, resp_ok=0, reject_count=1.
- Dest=10 free cell with count 1 -> lg_dest_full=1. Dest=3 tableau with count 19 -> lg_dest_full=1. Dest=3 with count 18 -> lg_dest_full=0.
- 52 legal moves into home locations -> game_won=1 after the 52nd commit; next request with lg_valid=1 -> resp_ok=0, no pop/push.
- req_valid held high during busy states -> only one acceptance; rst asserted in EVAL -> no pop_en, push_en, or resp_valid; req_ready=1 and counters 0 the cycle after.

Source files
------------

// File: rtl/freecell_move_ctrl.sv
// FreeCell move controller: fetches source/dest piles, drives the legality checker,
// commits legal moves to board storage and answers with a fixed-latency response.
module freecell_move_ctrl #(
  parameter int COL_DEPTH = 19,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_source,
  input  logic [3:0]       req_dest,
  output logic             resp_valid,
  output logic             resp_ok,
  output logic [3:0]       rd_loc,
  input  logic [5:0]       rd_card,
  input  logic [4:0]       rd_count,
  output logic             pop_en,
  output logic [3:0]       pop_loc,
  output logic             push_en,
  output logic [3:0]       push_loc,
  output logic [5:0]       push_card,
  output logic [3:0]       lg_source,
  output logic [3:0]       lg_dest,
  output logic             lg_src_empty,
  output logic             lg_dest_full,
  output logic             lg_dest_empty,
  output logic [5:0]       lg_src_card,
  output logic [5:0]       lg_dest_card,
  input  logic             lg_valid,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] reject_count,
  output logic             game_won
);

  typedef enum logic [2:0] {
    IDLE, RDSRC, RDDST, CAPT, EVAL, COMMIT, RESP
  } state_t;

  state_t     state, state_next;
  logic [3:0] source, dest;
  logic       ok;
  logic [5:0] home_count;
  logic       dest_full;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid && req_ready) state_next = RDSRC;
      RDSRC:   state_next = RDDST;
      RDDST:   state_next = CAPT;
      CAPT:    state_next = EVAL;
      EVAL:    state_next = COMMIT;
      COMMIT:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fullness depends on the kind of location: free cells hold one card, homes thirteen.
  always_comb begin
    dest_full = 1'b0;
    case (dest[3:2])
      2'b10:   dest_full = (rd_count >= 5'd1);
      2'b11:   dest_full = (rd_count >= 5'd13);
      default: dest_full = (rd_count >= 5'(COL_DEPTH));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_ok       <= 1'b0;
      pop_en        <= 1'b0;
      push_en       <= 1'b0;
      rd_loc        <= 4'd0;
      pop_loc       <= 4'd0;
      push_loc      <= 4'd0;
      push_card     <= 6'd0;
      lg_source     <= 4'd0;
      lg_dest       <= 4'd0;
      lg_src_empty  <= 1'b0;
      lg_dest_full  <= 1'b0;
      lg_dest_empty <= 1'b0;
      lg_src_card   <= 6'd0;
      lg_dest_card  <= 6'd0;
      source        <= 4'd0;
      dest          <= 4'd0;
      ok            <= 1'b0;
      move_count    <= '0;
      reject_count  <= '0;
      home_count    <= 6'd0;
      game_won      <= 1'b0;
    end else begin
      state      <= state_next;
      pop_en     <= 1'b0;
      push_en    <= 1'b0;
      resp_valid <= 1'b0;
      game_won   <= game_won | (home_count == 6'd52);
      // Each state's registered outputs are loaded on the edge that enters it.
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            source    <= req_source;
            dest      <= req_dest;
            rd_loc    <= req_source;
            req_ready <= 1'b0;
          end
        end
        RDSRC: rd_loc <= dest;
        RDDST: begin
          lg_source    <= source;
          lg_dest      <= dest;
          lg_src_card  <= rd_card;
          lg_src_empty <= (rd_count == 5'd0);
        end
        CAPT: begin
          lg_dest_card  <= rd_card;
          lg_dest_empty <= (rd_count == 5'd0);
          lg_dest_full  <= dest_full;
        end
        EVAL: begin
          ok        <= lg_valid & ~game_won;
          pop_en    <= lg_valid & ~game_won;
          push_en   <= lg_valid & ~game_won;
          pop_loc   <= source;
          push_loc  <= dest;
          push_card <= lg_src_card;
        end
        COMMIT: begin
          if (ok) begin
            move_count <= move_count + CNT_W'(1);
            if (dest[3:2] == 2'b11) home_count <= home_count + 6'd1;
          end else begin
            reject_count <= reject_count + CNT_W'(1);
          end
          resp_valid <= 1'b1;
          resp_ok    <= ok;
        end
        RESP: req_ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freecell_move_ctrl.sv
// Directed bench for freecell_move_ctrl: board storage model with one-cycle read
// latency, checker verdict forced per vector, hand-computed expectations.
module tb_freecell_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_source = 4'd0;
  logic [3:0]  req_dest = 4'd0;
  logic        resp_valid, resp_ok;
  logic [3:0]  rd_loc;
  logic [5:0]  rd_card = 6'd0;
  logic [4:0]  rd_count = 5'd0;
  logic        pop_en, push_en;
  logic [3:0]  pop_loc, push_loc;
  logic [5:0]  push_card;
  logic [3:0]  lg_source, lg_dest;
  logic        lg_src_empty, lg_dest_full, lg_dest_empty;
  logic [5:0]  lg_src_card, lg_dest_card;
  logic        lg_valid = 1'b0;
  logic [15:0] move_count, reject_count;
  logic        game_won;

  logic [5:0]  card_mem [16];
  logic [4:0]  cnt_mem  [16];

  int checks = 0;
  int failures = 0;

  int obs_rd1, obs_rd2, pop_n, push_n, pop_k, resp_n, resp_k, busy_ready, ready7;
  int obs_resp_ok, obs_pop_loc, obs_push_loc, obs_push_card;
  int obs_src_empty, obs_dest_full, obs_dest_empty, obs_lg_src, obs_lg_dst;
  int ok_moves;

  freecell_move_ctrl #(.COL_DEPTH(19), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_source(req_source), .req_dest(req_dest),
    .resp_valid(resp_valid), .resp_ok(resp_ok),
    .rd_loc(rd_loc), .rd_card(rd_card), .rd_count(rd_count),
    .pop_en(pop_en), .pop_loc(pop_loc),
    .push_en(push_en), .push_loc(push_loc), .push_card(push_card),
    .lg_source(lg_source), .lg_dest(lg_dest),
    .lg_src_empty(lg_src_empty), .lg_dest_full(lg_dest_full),
    .lg_dest_empty(lg_dest_empty),
    .lg_src_card(lg_src_card), .lg_dest_card(lg_dest_card),
    .lg_valid(lg_valid),
    .move_count(move_count), .reject_count(reject_count), .game_won(game_won)
  );

  always #5 clk = ~clk;

  // Board storage returns the addressed pile one cycle after rd_loc.
  always @(posedge clk) begin
    rd_card  <= card_mem[rd_loc];
    rd_count <= cnt_mem[rd_loc];
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Issue one request and watch the 7 cycles that follow the acceptance edge.
  task automatic applyStimulus(input logic [3:0] src, input logic [3:0] dst,
                               input logic verdict, input logic hold);
    obs_rd1 = -1; obs_rd2 = -1; pop_n = 0; push_n = 0; pop_k = -1;
    resp_n = 0; resp_k = -1; busy_ready = 0; ready7 = -1; obs_resp_ok = -1;
    obs_pop_loc = -1; obs_push_loc = -1; obs_push_card = -1;
    req_source = src; req_dest = dst; lg_valid = verdict; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (k == 1 && !hold) req_valid = 1'b0;
      if (k == 6) req_valid = 1'b0;
      if (k == 1) obs_rd1 = rd_loc;
      if (k == 2) obs_rd2 = rd_loc;
      if (k == 4) begin
        obs_src_empty  = lg_src_empty;
        obs_dest_full  = lg_dest_full;
        obs_dest_empty = lg_dest_empty;
        obs_lg_src     = lg_source;
        obs_lg_dst     = lg_dest;
      end
      if (pop_en) begin
        pop_n++; pop_k = k;
        obs_pop_loc = pop_loc; obs_push_loc = push_loc; obs_push_card = push_card;
      end
      if (push_en) push_n++;
      if (resp_valid) begin
        resp_n++; resp_k = k; obs_resp_ok = resp_ok;
      end
      if (k < 7 && req_ready) busy_ready++;
      if (k == 7) ready7 = req_ready;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      card_mem[i] = 6'd0;
      cnt_mem[i]  = 5'd0;
    end
    card_mem[0] = 6'b10_0101; cnt_mem[0] = 5'd3;
    card_mem[1] = 6'b01_0111; cnt_mem[1] = 5'd2;
    card_mem[2] = 6'b00_1000; cnt_mem[2] = 5'd4;
    cnt_mem[10] = 5'd1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset resp_valid", resp_valid, 0);
    checkOutput("reset pop_en", pop_en, 0);
    checkOutput("reset rd_loc", rd_loc, 0);
    checkOutput("reset move_count", move_count, 0);
    checkOutput("reset game_won", game_won, 0);

    // Legal tableau -> free cell move.
    applyStimulus(4'd0, 4'd8, 1'b1, 1'b0);
    checkOutput("m1 rd_loc src", obs_rd1, 0);
    checkOutput("m1 rd_loc dst", obs_rd2, 8);
    checkOutput("m1 lg_source", obs_lg_src, 0);
    checkOutput("m1 lg_dest", obs_lg_dst, 8);
    checkOutput("m1 lg_dest_empty", obs_dest_empty, 1);
    checkOutput("m1 pop cycles", pop_n, 1);
    checkOutput("m1 push cycles", push_n, 1);
    checkOutput("m1 pop cycle index", pop_k, 5);
    checkOutput("m1 pop_loc", obs_pop_loc, 0);
    checkOutput("m1 push_loc", obs_push_loc, 8);
    checkOutput("m1 push_card", obs_push_card, 6'b10_0101);
    checkOutput("m1 resp latency", resp_k, 6);
    checkOutput("m1 resp count", resp_n, 1);
    checkOutput("m1 resp_ok", obs_resp_ok, 1);
    checkOutput("m1 busy req_ready", busy_ready, 0);
    checkOutput("m1 ready after", ready7, 1);
    checkOutput("m1 move_count", move_count, 1);

    // Empty free cell as source, checker refuses.
    applyStimulus(4'd9, 4'd1, 1'b0, 1'b0);
    checkOutput("m2 lg_src_empty", obs_src_empty, 1);
    checkOutput("m2 no pop", pop_n, 0);
    checkOutput("m2 no push", push_n, 0);
    checkOutput("m2 resp latency", resp_k, 6);
    checkOutput("m2 resp_ok", obs_resp_ok, 0);
    checkOutput("m2 reject_count", reject_count, 1);

    // Destination fullness boundaries.
    applyStimulus(4'd0, 4'd10, 1'b0, 1'b0);
    checkOutput("full freecell cnt1", obs_dest_full, 1);
    checkOutput("freecell not empty", obs_dest_empty, 0);
    cnt_mem[3] = 5'd19;
    applyStimulus(4'd0, 4'd3, 1'b0, 1'b0);
    checkOutput("full tableau cnt19", obs_dest_full, 1);
    cnt_mem[3] = 5'd18;
    applyStimulus(4'd0, 4'd3, 1'b0, 1'b0);
    checkOutput("tableau cnt18 not full", obs_dest_full, 0);
    cnt_mem[13] = 5'd13;
    applyStimulus(4'd0, 4'd13, 1'b0, 1'b0);
    checkOutput("full home cnt13", obs_dest_full, 1);
    cnt_mem[13] = 5'd0;
    checkOutput("reject_count after 5", reject_count, 5);

    // req_valid held through the busy states: still a single acceptance.
    applyStimulus(4'd1, 4'd2, 1'b1, 1'b1);
    checkOutput("hold resp count", resp_n, 1);
    checkOutput("hold pop cycles", pop_n, 1);
    checkOutput("hold move_count", move_count, 2);
    resp_n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) resp_n++;
    end
    checkOutput("hold no second resp", resp_n, 0);

    // Fill the homes with 52 legal moves.
    ok_moves = 0;
    for (int i = 0; i < 52; i++) begin
      applyStimulus(4'd0, 4'(12 + (i % 4)), 1'b1, 1'b0);
      if (obs_resp_ok == 1 && pop_n == 1) ok_moves++;
      if (i == 50) checkOutput("won after 51", game_won, 0);
    end
    checkOutput("home moves committed", ok_moves, 52);
    checkOutput("game_won after 52", game_won, 1);
    checkOutput("move_count after homes", move_count, 54);

    applyStimulus(4'd1, 4'd2, 1'b1, 1'b0);
    checkOutput("won resp_ok", obs_resp_ok, 0);
    checkOutput("won resp latency", resp_k, 6);
    checkOutput("won no pop", pop_n, 0);
    checkOutput("won no push", push_n, 0);
    checkOutput("won reject_count", reject_count, 6);
    checkOutput("won move_count", move_count, 54);

    // Reset during EVAL drops the pending commit and response.
    req_source = 4'd0; req_dest = 4'd8; lg_valid = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst req_ready", req_ready, 1);
    checkOutput("rst move_count", move_count, 0);
    checkOutput("rst reject_count", reject_count, 0);
    checkOutput("rst game_won", game_won, 0);
    pop_n = 0; resp_n = 0;
    repeat (6) begin
      if (pop_en || push_en) pop_n++;
      if (resp_valid) resp_n++;
      @(posedge clk); #1;
    end
    checkOutput("rst no write", pop_n, 0);
    checkOutput("rst no resp", resp_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
